lc3_isdu: RTL and testbench
===========================

// Module: lc3_isdu
// PURPOSE
//  LC-3 instruction sequencer/decoder: Moore FSM driving every datapath load/gate/mux control.
//  Consumes BEN from the branch-enable unit; produces that unit's LD_BEN/LD_CC strobes.
//  Supports fetch, decode, ADD/AND/NOT/BR/JMP/JSR/LDR/STR and PAUSE (opcode 4'b1101).
//  Memory accesses hold for MEM_WAIT cycles to meet synchronous SRAM latency.
// PARAMETERS
//  MEM_WAIT  2  cycles each memory state is held (legal 1..7)
// PORTS
//  Clk        in   1  system clock, all state updates on posedge
//  Reset_n    in   1  synchronous, active-low reset
//  Run        in   1  start execution from Halted
//  Continue   in   1  resume from PAUSE (level, two-phase handshake)
//  Opcode     in   4  IR[15:12]
//  IR_5       in   1  IR[5], immediate select for ADD/AND
//  IR_11      in   1  IR[11], JSR vs JSRR
//  BEN        in   1  registered branch enable
//  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out 1 each  register loads
//  GatePC, GateMDR, GateALU, GateMARMUX  out 1 each  bus drivers, at most one high per cycle
//  PCMUX      out  2  0=PC+1, 1=bus, 2=adder
//  DRMUX, SR1MUX, SR2MUX, ADDR1MUX  out 1 each  (DRMUX 1=R7; SR1MUX 1=IR[8:6]; SR2MUX 1=SEXT imm5; ADDR1MUX 1=SR1)
//  ADDR2MUX   out  2  0=0, 1=off6, 2=off9, 3=off11
//  ALUK       out  2  0=ADD, 1=AND, 2=NOT, 3=PASS A
//  Mem_OE_n, Mem_WE_n  out 1 each  active-low SRAM controls
// BEHAVIOUR
//  - Reset_n=0 at posedge: state<=Halted, wait counter<=0. All outputs derive from state; in Halted
//    every load/gate is 0, every mux/ALUK is 0, Mem_OE_n=Mem_WE_n=1. Reset mid-instruction aborts it.
//  - Outputs combinational from current state only (Moore); no input-to-output paths.
//  - Halted: Run=1 -> S18, else stay. Run is ignored in all other states.
//  - Fetch: S18 (GatePC, LD_MAR, PCMUX=0, LD_PC) -> S33 (Mem_OE_n=0, held MEM_WAIT cycles, LD_MDR
//    on final cycle only) -> S35 (GateMDR, LD_IR) -> S32 (LD_BEN=1) -> decode.
//  - Decode from S32: 0001 S1, 0101 S5, 1001 S9, 0000 S0, 1100 S12, 0100 S4, 0110 S6, 0111 S7,
//    1101 PauseIR1; any other opcode -> S18 (NOP).
//  - S1/S5: SR2MUX=IR_5, ALUK=ADD/AND; S9: ALUK=NOT. All: GateALU, LD_REG, LD_CC, SR1MUX=1 -> S18.
//  - S0: BEN=1 -> S22 (ADDR2MUX=2, PCMUX=2, LD_PC) -> S18; BEN=0 -> S18.
//  - S12: SR1MUX=1, ALUK=PASS, GateALU, PCMUX=1, LD_PC -> S18.
//  - S4: GatePC, DRMUX=1, LD_REG -> IR_11 ? S21 (ADDR2MUX=3, PCMUX=2, LD_PC)
//    : S20 (SR1MUX=1, ADDR1MUX=1, ADDR2MUX=0, PCMUX=2, LD_PC) -> S18.
//  - S6: ADDR1MUX=1, ADDR2MUX=1, SR1MUX=1, GateMARMUX, LD_MAR -> S25 (Mem_OE_n=0, MEM_WAIT cycles,
//    LD_MDR final cycle) -> S27 (GateMDR, LD_REG, LD_CC) -> S18.
//  - S7: address as S6, LD_MAR -> S23 (SR1MUX=0 selects IR[11:9], ALUK=PASS, GateALU, LD_MDR)
//    -> S16 (Mem_WE_n=0 for MEM_WAIT cycles) -> S18.
//  - PauseIR1: LD_LED=1 on entry cycle only; stay until Continue=1 -> PauseIR2; stay until
//    Continue=0 -> S18. Continue held high across PAUSE executes it exactly once.
//  - Wait counter: 3 bits; cleared entering S33/S25/S16; increments while in them; exit when
//    count==MEM_WAIT-1. MEM_WAIT=1 gives single-cycle memory states.
//  - Exactly one gate active or none; Mem_OE_n and Mem_WE_n never both 0.
// STRUCTURE
//  - lc3_pkg: state_t enum, opcode localparams (OP_ADD...OP_PAUSE), PCMUX/ADDR2MUX/ALUK enums.
//  - Sub-module isdu_wait_ctr (clear, enable, MEM_WAIT param, done flag); rest is one next-state
//    always_comb, one output always_comb, one state always_ff.
// TESTING
//  1. Reset_n=0 during S25 of LDR -> next cycle Halted, all loads 0, Mem_OE_n=Mem_WE_n=1.
//  2. Run pulse, Opcode=0001, IR_5=1, MEM_WAIT=2 -> S18,S33,S33,S35,S32,S1,S18; LD_CC high in S1 only.
//  3. Opcode=0000 with BEN=1 -> S0,S22 with LD_PC=1,PCMUX=2; BEN=0 -> S0 then S18, LD_PC never high.
//  4. Opcode=0111 -> Mem_WE_n=0 exactly MEM_WAIT cycles in S16, Mem_OE_n stays 1 throughout.
//  5. Opcode=1101, Continue held 1 -> PauseIR1,PauseIR2, waits; Continue=0 -> S18; LD_LED one pulse.
//  6. Opcode=1000 (undefined) -> S32 then S18, no LD_REG/LD_PC/LD_CC asserted; sweep MEM_WAIT=1,3.

Source files
------------

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - LC-3 sequencer states, opcodes and datapath select encodings
package lc3_pkg;

  typedef enum logic [4:0] {
    S_HALT, S_18, S_33, S_35, S_32,
    S_1, S_5, S_9, S_0, S_22, S_12,
    S_4, S_21, S_20,
    S_6, S_25, S_27,
    S_7, S_23, S_16,
    S_PAUSE1, S_PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  typedef enum logic [1:0] {PC_INC = 2'd0, PC_BUS = 2'd1, PC_ADDER = 2'd2} pcmux_t;
  typedef enum logic [1:0] {A2_ZERO = 2'd0, A2_OFF6 = 2'd1, A2_OFF9 = 2'd2, A2_OFF11 = 2'd3} addr2_t;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_AND = 2'd1, ALU_NOT = 2'd2, ALU_PASS = 2'd3} aluk_t;

  // States that talk to the SRAM and are stretched by the wait counter.
  function automatic logic is_mem_state(state_t s);
    return (s == S_33) || (s == S_25) || (s == S_16);
  endfunction

endpackage

// File: rtl/isdu_wait_ctr.sv
// rtl/isdu_wait_ctr.sv - memory-state hold counter; done on the last hold cycle
module isdu_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (enable) count_d = count_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign done = (count_q == LAST);

endmodule

// File: rtl/lc3_isdu.sv
// rtl/lc3_isdu.sv - LC-3 Moore sequencer driving all datapath loads, gates and muxes
module lc3_isdu
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
  output logic       GatePC, GateMDR, GateALU, GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE_n, Mem_WE_n
);

  state_t state_q, state_d;
  logic   led_done_q, led_done_d;
  logic   in_mem, wait_done;

  assign in_mem = is_mem_state(state_q);

  // Counter sits at zero outside memory states so every entry starts a fresh hold.
  isdu_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait_ctr (
    .clk    (Clk),
    .reset_n(Reset_n),
    .clear  (!in_mem),
    .enable (in_mem),
    .done   (wait_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HALT:   if (Run) state_d = S_18;
      S_18:     state_d = S_33;
      S_33:     if (wait_done) state_d = S_35;
      S_35:     state_d = S_32;
      S_32: begin
        unique case (Opcode)
          OP_ADD:   state_d = S_1;
          OP_AND:   state_d = S_5;
          OP_NOT:   state_d = S_9;
          OP_BR:    state_d = S_0;
          OP_JMP:   state_d = S_12;
          OP_JSR:   state_d = S_4;
          OP_LDR:   state_d = S_6;
          OP_STR:   state_d = S_7;
          OP_PAUSE: state_d = S_PAUSE1;
          default:  state_d = S_18;
        endcase
      end
      S_0:      state_d = BEN ? S_22 : S_18;
      S_4:      state_d = IR_11 ? S_21 : S_20;
      S_6:      state_d = S_25;
      S_25:     if (wait_done) state_d = S_27;
      S_7:      state_d = S_23;
      S_23:     state_d = S_16;
      S_16:     if (wait_done) state_d = S_18;
      S_PAUSE1: if (Continue) state_d = S_PAUSE2;
      S_PAUSE2: if (!Continue) state_d = S_18;
      S_1, S_5, S_9, S_22, S_12, S_21, S_20, S_27: state_d = S_18;
      default:  state_d = S_HALT;
    endcase
  end

  // LD_LED marks only the first cycle spent in PAUSE1, however long it waits there.
  assign led_done_d = (state_q == S_PAUSE1);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_HALT;
      led_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_done_q <= led_done_d;
    end
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PC_INC; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ADDR1MUX = 1'b0;
    ADDR2MUX = A2_ZERO; ALUK = ALU_ADD;
    Mem_OE_n = 1'b1; Mem_WE_n = 1'b1;
    unique case (state_q)
      S_18: begin GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = PC_INC; LD_PC = 1'b1; end
      S_33, S_25: begin Mem_OE_n = 1'b0; LD_MDR = wait_done; end
      S_35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_32: LD_BEN = 1'b1;
      S_1, S_5, S_9: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = 1'b1;
        SR2MUX  = (state_q == S_9) ? 1'b0 : IR_5;
        ALUK    = (state_q == S_1) ? ALU_ADD : (state_q == S_5) ? ALU_AND : ALU_NOT;
      end
      S_22: begin ADDR2MUX = A2_OFF9; PCMUX = PC_ADDER; LD_PC = 1'b1; end
      S_12: begin SR1MUX = 1'b1; ALUK = ALU_PASS; GateALU = 1'b1; PCMUX = PC_BUS; LD_PC = 1'b1; end
      S_4:  begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S_21: begin ADDR2MUX = A2_OFF11; PCMUX = PC_ADDER; LD_PC = 1'b1; end
      S_20: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = A2_ZERO; PCMUX = PC_ADDER; LD_PC = 1'b1;
      end
      S_6, S_7: begin
        ADDR1MUX = 1'b1; ADDR2MUX = A2_OFF6; SR1MUX = 1'b1; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_23: begin SR1MUX = 1'b0; ALUK = ALU_PASS; GateALU = 1'b1; LD_MDR = 1'b1; end
      S_16: Mem_WE_n = 1'b0;
      S_PAUSE1: LD_LED = !led_done_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_isdu.sv
// tb/tb_lc3_isdu.sv - scoreboard bench for lc3_isdu at MEM_WAIT 2, 1 and 3
module tb_lc3_isdu;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic mem_oe_n, mem_we_n;
  } ctl_t;

  typedef enum {
    E_HALT, E_18, E_33W, E_33F, E_35, E_32, E_1, E_5, E_9, E_0, E_22, E_12,
    E_4, E_21, E_20, E_6, E_25W, E_25F, E_27, E_7, E_23, E_16, E_P1L, E_P1N, E_P2
  } exp_t;

  logic Clk = 1'b0, Reset_n = 1'b0, Run = 1'b0, Continue = 1'b0;
  logic [3:0] Opcode = 4'b0000;
  logic IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;

  wire ld_mar [3], ld_mdr [3], ld_ir [3], ld_ben [3], ld_cc [3], ld_reg [3], ld_pc [3], ld_led [3];
  wire gate_pc [3], gate_mdr [3], gate_alu [3], gate_marmux [3];
  wire [1:0] pcmux [3], addr2mux [3], aluk [3];
  wire drmux [3], sr1mux [3], sr2mux [3], addr1mux [3], mem_oe_n [3], mem_we_n [3];

  int mw [3] = '{2, 1, 3};
  int sel = 0;
  int n_tests = 0;
  int n_fail = 0;
  ctl_t  exp_q [$];
  string tag_q [$];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lc3_isdu #(.MEM_WAIT(g == 0 ? 2 : (g == 1 ? 1 : 3))) u_dut (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
      .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(ld_mar[g]), .LD_MDR(ld_mdr[g]), .LD_IR(ld_ir[g]), .LD_BEN(ld_ben[g]),
      .LD_CC(ld_cc[g]), .LD_REG(ld_reg[g]), .LD_PC(ld_pc[g]), .LD_LED(ld_led[g]),
      .GatePC(gate_pc[g]), .GateMDR(gate_mdr[g]), .GateALU(gate_alu[g]), .GateMARMUX(gate_marmux[g]),
      .PCMUX(pcmux[g]), .DRMUX(drmux[g]), .SR1MUX(sr1mux[g]), .SR2MUX(sr2mux[g]),
      .ADDR1MUX(addr1mux[g]), .ADDR2MUX(addr2mux[g]), .ALUK(aluk[g]),
      .Mem_OE_n(mem_oe_n[g]), .Mem_WE_n(mem_we_n[g])
    );
  end

  function automatic ctl_t observe(int i);
    ctl_t c;
    c = {ld_mar[i], ld_mdr[i], ld_ir[i], ld_ben[i], ld_cc[i], ld_reg[i], ld_pc[i], ld_led[i],
         gate_pc[i], gate_mdr[i], gate_alu[i], gate_marmux[i], pcmux[i],
         drmux[i], sr1mux[i], sr2mux[i], addr1mux[i], addr2mux[i], aluk[i],
         mem_oe_n[i], mem_we_n[i]};
    return c;
  endfunction

  function automatic ctl_t exp_vec(exp_t e, logic ir5);
    ctl_t c = '0;
    c.mem_oe_n = 1'b1;
    c.mem_we_n = 1'b1;
    case (e)
      E_18:  begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      E_33W, E_25W: c.mem_oe_n = 0;
      E_33F, E_25F: begin c.mem_oe_n = 0; c.ld_mdr = 1; end
      E_35:  begin c.gate_mdr = 1; c.ld_ir = 1; end
      E_32:  c.ld_ben = 1;
      E_1:   begin c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 1; c.sr2mux = ir5; end
      E_5:   begin c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 1; c.sr2mux = ir5; c.aluk = 2'd1; end
      E_9:   begin c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 1; c.aluk = 2'd2; end
      E_22:  begin c.addr2mux = 2'd2; c.pcmux = 2'd2; c.ld_pc = 1; end
      E_12:  begin c.sr1mux = 1; c.aluk = 2'd3; c.gate_alu = 1; c.pcmux = 2'd1; c.ld_pc = 1; end
      E_4:   begin c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; end
      E_21:  begin c.addr2mux = 2'd3; c.pcmux = 2'd2; c.ld_pc = 1; end
      E_20:  begin c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'd2; c.ld_pc = 1; end
      E_6, E_7: begin c.addr1mux = 1; c.addr2mux = 2'd1; c.sr1mux = 1; c.gate_marmux = 1; c.ld_mar = 1; end
      E_27:  begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      E_23:  begin c.aluk = 2'd3; c.gate_alu = 1; c.ld_mdr = 1; end
      E_16:  c.mem_we_n = 0;
      E_P1L: c.ld_led = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic push(exp_t e);
    exp_q.push_back(exp_vec(e, IR_5));
    tag_q.push_back($sformatf("%s/mw%0d", e.name(), mw[sel]));
  endtask

  task automatic push_fetch();
    push(E_18);
    for (int i = 1; i < mw[sel]; i++) push(E_33W);
    push(E_33F);
    push(E_35);
    push(E_32);
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic check_one();
    ctl_t  e, o;
    string t;
    int    gates;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observe(sel);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
    gates = int'(o.gate_pc) + int'(o.gate_mdr) + int'(o.gate_alu) + int'(o.gate_marmux);
    n_tests++;
    assert (gates <= 1 && !(o.mem_oe_n === 1'b0 && o.mem_we_n === 1'b0)) else begin
      n_fail++;
      $error("FAIL bus_excl %s observed gates=%0d oe_n=%b we_n=%b expected gates<=1 and not both low",
             t, gates, o.mem_oe_n, o.mem_we_n);
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      tick();
      check_one();
    end
  endtask

  task automatic reset_all();
    Run = 0; Continue = 0; Reset_n = 0;
    tick();
    Reset_n = 1;
    push(E_HALT);
    check_one();
  endtask

  // Expected entries must already be queued; the first one is S18 after the Run pulse.
  task automatic go();
    Run = 1;
    tick();
    check_one();
    Run = 0;
    drain();
  endtask

  initial begin
    @(negedge Clk);
    sel = 0;

    reset_all();
    Opcode = 4'b0110;
    push_fetch(); push(E_6); push(E_25W);
    go();
    Reset_n = 0;
    push(E_HALT); tick(); check_one();
    Reset_n = 1;
    push(E_HALT); tick(); check_one();
    push(E_HALT); tick(); check_one();

    reset_all();
    push_fetch(); push(E_6); push(E_25W); push(E_25F); push(E_27); push(E_18);
    go();

    reset_all();
    Opcode = 4'b0001; IR_5 = 1;
    push_fetch(); push(E_1); push(E_18);
    go();

    reset_all();
    Opcode = 4'b0101; IR_5 = 0;
    push_fetch(); push(E_5); push(E_18);
    go();

    reset_all();
    Opcode = 4'b1001; IR_5 = 1;
    push_fetch(); push(E_9); push(E_18);
    go();

    reset_all();
    Opcode = 4'b0000; BEN = 1;
    push_fetch(); push(E_0); push(E_22); push(E_18);
    go();

    reset_all();
    BEN = 0;
    push_fetch(); push(E_0); push(E_18); push(E_33W);
    go();

    reset_all();
    Opcode = 4'b1100;
    push_fetch(); push(E_12); push(E_18);
    go();

    reset_all();
    Opcode = 4'b0100; IR_11 = 1;
    push_fetch(); push(E_4); push(E_21); push(E_18);
    go();

    reset_all();
    IR_11 = 0;
    push_fetch(); push(E_4); push(E_20); push(E_18);
    go();

    reset_all();
    Opcode = 4'b0111;
    push_fetch(); push(E_7); push(E_23); push(E_16); push(E_16); push(E_18);
    go();

    reset_all();
    Opcode = 4'b1101;
    Continue = 1;
    push_fetch(); push(E_P1L); push(E_P2); push(E_P2); push(E_P2);
    Run = 1; tick(); check_one(); Run = 0; drain();
    Continue = 0;
    push(E_18); tick(); check_one();

    reset_all();
    push_fetch(); push(E_P1L); push(E_P1N); push(E_P1N);
    go();
    Continue = 1;
    push(E_P2); tick(); check_one();
    Continue = 0;
    push(E_18); tick(); check_one();

    for (int s = 0; s < 3; s++) begin
      sel = s;
      reset_all();
      Opcode = 4'b1000;
      push_fetch(); push(E_18);
      go();
      if (s != 0) begin
        reset_all();
        Opcode = 4'b0111;
        push_fetch(); push(E_7); push(E_23);
        for (int i = 0; i < mw[sel]; i++) push(E_16);
        push(E_18);
        go();
        reset_all();
        Opcode = 4'b0110;
        push_fetch(); push(E_6);
        for (int i = 1; i < mw[sel]; i++) push(E_25W);
        push(E_25F); push(E_27); push(E_18);
        go();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
